// File: rtl/disp_pkg.sv
// rtl/disp_pkg.sv - shared display-path types and constants
`timescale 1ns/1ps
package disp_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } conv_state_t;

    // Width of one BCD digit
    localparam int DIGIT_W        = 4;
    // Digits at or above this value get +3 before each shift
    localparam int ADD3_THRESHOLD = 5;

    // Defaults shared with the multiplier and the display driver
    localparam int DEFAULT_PROD_W = 8;
    localparam int DEFAULT_NDIG   = 3;

endpackage

// File: rtl/product_bcd_converter_if.sv
// rtl/product_bcd_converter_if.sv - product-in / sign+BCD-out handshake bundle
`timescale 1ns/1ps
interface product_bcd_converter_if
    import disp_pkg::*;
#(
    parameter int PROD_W = DEFAULT_PROD_W,
    parameter int NDIG   = DEFAULT_NDIG
);

    logic [PROD_W-1:0]       product;
    logic                    start;
    logic                    busy;
    logic                    done;
    logic                    sign;
    logic [DIGIT_W*NDIG-1:0] bcd;

    // Multiplier side: supplies the operand and the request
    modport master (
        output product,
        output start,
        input  busy,
        input  done,
        input  sign,
        input  bcd
    );

    // Converter side
    modport slave (
        input  product,
        input  start,
        output busy,
        output done,
        output sign,
        output bcd
    );

endinterface

// File: rtl/bcd_digit_adjust.sv
// rtl/bcd_digit_adjust.sv - combinational double-dabble "if >= 5 add 3" digit cell
`timescale 1ns/1ps
module bcd_digit_adjust
    import disp_pkg::*;
(
    input  logic [DIGIT_W-1:0] digit_in,
    output logic [DIGIT_W-1:0] digit_out
);

    // Pre-correct so the following left shift carries into the next decade
    always_comb begin
        digit_out = digit_in;
        if (digit_in >= DIGIT_W'(ADD3_THRESHOLD)) begin
            digit_out = digit_in + DIGIT_W'(3);
        end
    end

endmodule

// File: rtl/product_bcd_converter.sv
// rtl/product_bcd_converter.sv - sequential signed product to sign + BCD converter
`timescale 1ns/1ps
module product_bcd_converter
    import disp_pkg::*;
#(
    parameter int PROD_W = DEFAULT_PROD_W,
    parameter int NDIG   = DEFAULT_NDIG
) (
    input  logic                    clock,
    input  logic                    reset_n,
    product_bcd_converter_if.slave  bus
);

    localparam int BCD_W = DIGIT_W * NDIG;
    localparam int CNT_W = $clog2(PROD_W + 1);

    // The largest magnitude, 2^(PROD_W-1), must fit in NDIG decimal digits
    if (10 ** NDIG <= 2 ** (PROD_W - 1)) begin : g_range_check
        $error("product_bcd_converter: NDIG too small for PROD_W");
    end

    conv_state_t       state, state_next;
    logic [PROD_W-1:0] mag, mag_next;
    logic [BCD_W-1:0]  scratch, scratch_next, scratch_adj;
    logic [CNT_W-1:0]  count, count_next;
    logic              sign_cap, sign_cap_next;
    logic              sign_q, sign_next;
    logic [BCD_W-1:0]  bcd_q, bcd_next;
    logic              done_q, done_next;

    logic [BCD_W+PROD_W-1:0] shifted;

    for (genvar d = 0; d < NDIG; d++) begin : g_adjust
        bcd_digit_adjust u_adjust (
            .digit_in  (scratch[d*DIGIT_W +: DIGIT_W]),
            .digit_out (scratch_adj[d*DIGIT_W +: DIGIT_W])
        );
    end

    assign shifted  = {scratch_adj, mag} << 1;

    assign bus.busy = (state == SHIFT);
    assign bus.done = done_q;
    assign bus.sign = sign_q;
    assign bus.bcd  = bcd_q;

    // State register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and datapath update; outputs only change on the final shift
    always_comb begin
        state_next    = state;
        mag_next      = mag;
        scratch_next  = scratch;
        count_next    = count;
        sign_cap_next = sign_cap;
        sign_next     = sign_q;
        bcd_next      = bcd_q;
        done_next     = 1'b0;

        case (state)
            IDLE: begin
                if (bus.start) begin
                    sign_cap_next = bus.product[PROD_W-1];
                    // Most-negative input negates to itself, which is the correct unsigned magnitude
                    mag_next      = bus.product[PROD_W-1] ? PROD_W'(-bus.product) : bus.product;
                    scratch_next  = '0;
                    count_next    = '0;
                    state_next    = SHIFT;
                end
            end
            SHIFT: begin
                scratch_next = shifted[BCD_W+PROD_W-1 -: BCD_W];
                mag_next     = shifted[PROD_W-1:0];
                count_next   = count + CNT_W'(1);
                if (count == CNT_W'(PROD_W - 1)) begin
                    bcd_next   = shifted[BCD_W+PROD_W-1 -: BCD_W];
                    sign_next  = sign_cap;
                    done_next  = 1'b1;
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Datapath and output registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            mag      <= '0;
            scratch  <= '0;
            count    <= '0;
            sign_cap <= 1'b0;
            sign_q   <= 1'b0;
            bcd_q    <= '0;
            done_q   <= 1'b0;
        end else begin
            mag      <= mag_next;
            scratch  <= scratch_next;
            count    <= count_next;
            sign_cap <= sign_cap_next;
            sign_q   <= sign_next;
            bcd_q    <= bcd_next;
            done_q   <= done_next;
        end
    end

endmodule
